counter_run_arbiter: RTL and testbench



---
 rtl/counter_run_arbiter.sv | 156 +++++++++++++++
 tb/tb_counter_run_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_run_arbiter.sv
// counter_run_arbiter
//   Shares one CNT_W-bit up-counter between NUM_REQ requesters. Each
//   requester is granted in round-robin order. The counter is cleared and
//   then enabled until it reaches the requested length. The final count is
//   then returned with a one-cycle done pulse.
//
// Ports
//   clk, reset   : clock (rising edge); asynchronous active-high reset
//   req          : per-requester run request (level)
//   req_len      : per-requester target count, requester i at [i*CNT_W +: CNT_W]
//   count        : current value of the shared counter
//   cnt_reset    : synchronous reset strobe to the counter
//   cnt_enable   : count enable to the counter
//   gnt          : one-hot grant, held CLEAR..DONE
//   done         : one-cycle completion pulse to the grantee
//   result       : count at end of run, held until the next done
//   err          : pulses with done when the run ended by timeout
//   busy         : high whenever the FSM is not IDLE
module counter_run_arbiter #(
    parameter int CNT_W   = 4,
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    input  logic [CNT_W-1:0]         count,
    output logic                     cnt_reset,
    output logic                     cnt_enable,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [CNT_W-1:0]         result,
    output logic                     err,
    output logic                     busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [IDX_W-1:0]   r_idx, r_ptr, w_sel;
    logic               w_found;
    logic [CNT_W-1:0]   r_len;
    logic [TMR_W-1:0]   r_timer;
    logic               r_err;
    logic [CNT_W-1:0]   r_result;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_match, w_tmo, w_req_act, w_exit;

    // Round-robin pick: first set req bit at or above r_ptr, wrapping.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
    end

    assign w_match   = (count == r_len);
    assign w_tmo     = (r_timer == TMR_W'(TIMEOUT));
    assign w_req_act = req[r_idx];
    assign w_exit    = w_match || !w_req_act || w_tmo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        w_next     = r_state;
        cnt_reset  = 1'b0;
        cnt_enable = 1'b0;
        gnt        = '0;
        done       = '0;
        err        = 1'b0;
        busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                gnt       = w_onehot;
                cnt_reset = 1'b1;
                busy      = 1'b1;
                w_next    = S_RUN;
            end
            S_RUN: begin
                gnt  = w_onehot;
                busy = 1'b1;
                // Combinational so the counter stops exactly on len without overshoot.
                cnt_enable = !w_match && w_req_act && !w_tmo;
                if (w_exit) w_next = S_DONE;
            end
            S_DONE: begin
                gnt    = w_onehot;
                done   = w_onehot;
                err    = r_err;
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign result = r_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= '0;
            r_ptr    <= '0;
            r_len    <= '0;
            r_timer  <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx <= w_sel;
                        r_len <= req_len[int'(w_sel)*CNT_W +: CNT_W];
                    end
                end
                S_CLEAR: r_timer <= '0;
                S_RUN: begin
                    if (!w_tmo) r_timer <= r_timer + 1'b1;
                    if (w_exit) begin
                        r_result <= count;
                        // A match in the same cycle as the timeout is a clean finish.
                        r_err    <= w_tmo && !w_match;
                    end
                end
                S_DONE: begin
                    r_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_run_arbiter.sv
module tb_counter_run_arbiter;

    localparam int CNT_W = 4, NUM_REQ = 2, TIMEOUT = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_len;
    logic [CNT_W-1:0]         count;
    logic                     cnt_reset, cnt_enable, err, busy;
    logic [NUM_REQ-1:0]       gnt, done;
    logic [CNT_W-1:0]         result;
    logic                     stuck;

    int n_chk = 0;
    int n_err = 0;

    counter_run_arbiter #(.CNT_W(CNT_W), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len), .count(count),
        .cnt_reset(cnt_reset), .cnt_enable(cnt_enable), .gnt(gnt), .done(done),
        .result(result), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared counter model: synchronous reset, enable, optional stuck-at-0.
    always @(posedge clk) begin
        if (cnt_reset)                count <= '0;
        else if (cnt_enable && !stuck) count <= count + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        req     = '0;
        stuck   = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        int en_cnt, n_done, c;
        int exp_idx [4] = '{0, 1, 0, 1};
        int exp_res [4] = '{3, 4, 3, 4};
        req = '0; req_len = '0; stuck = 1'b0; count = '0; reset = 1'b0;
        #2;

        // Reset state
        do_reset;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_cnt_en", cnt_enable, 0);
        chk("rst_cnt_rst", cnt_reset, 0);

        // Test 1: req0, len 5
        req_len = {4'd9, 4'd5};
        req = 2'b01;                       // cycle 0
        tick;                              // cycle 1
        chk("t1_gnt_c1", gnt, 2'b01);
        chk("t1_cntrst_c1", cnt_reset, 1);
        chk("t1_en_c1", cnt_enable, 0);
        req_len = {4'd9, 4'd2};            // must be ignored
        en_cnt = 0;
        for (int cy = 2; cy <= 7; cy++) begin
            tick;
            chk($sformatf("t1_en_c%0d", cy), cnt_enable, (cy <= 6) ? 1 : 0);
            chk($sformatf("t1_done_c%0d", cy), done, 0);
        end
        tick;                              // cycle 8
        chk("t1_done", done, 2'b01);
        chk("t1_result", result, 5);
        chk("t1_err", err, 0);
        req = '0;
        tick;                              // cycle 9
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_gnt", gnt, 0);
        chk("t1_result_hold", result, 5);

        // Test 3: req1, len 0
        do_reset;
        req_len = {4'd0, 4'd9};
        req = 2'b10;
        tick;
        chk("t3_gnt", gnt, 2'b10);
        chk("t3_en_c1", cnt_enable, 0);
        tick;
        chk("t3_en_c2", cnt_enable, 0);
        chk("t3_done_c2", done, 0);
        tick;
        chk("t3_done", done, 2'b10);
        chk("t3_result", result, 0);
        chk("t3_err", err, 0);
        req = '0;
        tick;

        // Test 2: both requesting, alternation
        do_reset;
        req_len = {4'd4, 4'd3};
        req = 2'b11;
        n_done = 0;
        c = 0;
        while (n_done < 4 && c < 80) begin
            tick;
            c++;
            chk("t2_gnt_1hot", ($countones(gnt) <= 1) ? 1 : 0, 1);
            chk("t2_done_sub", ((done & ~gnt) == 0) ? 1 : 0, 1);
            if (done != 0) begin
                chk($sformatf("t2_idx%0d", n_done), (done == 2'b10) ? 1 : 0, exp_idx[n_done]);
                chk($sformatf("t2_res%0d", n_done), result, exp_res[n_done]);
                n_done++;
                if (n_done == 4) req = '0;
            end
        end
        chk("t2_ndone", n_done, 4);
        tick;

        // Test 4: counter stuck at 0 -> timeout
        do_reset;
        stuck = 1'b1;
        req_len = {4'd9, 4'd7};
        req = 2'b01;
        tick;                              // cycle 1
        en_cnt = 0;
        for (int cy = 2; cy <= 33; cy++) begin
            tick;
            if (cnt_enable) en_cnt++;
        end
        chk("t4_en_cycles", en_cnt, 32);
        tick;                              // cycle 34: timeout cycle
        chk("t4_en_tmo", cnt_enable, 0);
        chk("t4_done_early", done, 0);
        tick;                              // cycle 35
        chk("t4_done", done, 2'b01);
        chk("t4_err", err, 1);
        chk("t4_result", result, 0);
        req = '0;
        stuck = 1'b0;
        tick;
        chk("t4_err_pulse", err, 0);

        // Test 5: abort when count==2, then pointer moves to 1
        do_reset;
        req_len = {4'd3, 4'd10};
        req = 2'b01;
        tick; tick; tick; tick;            // cycle 4, count==2
        chk("t5_count_pre", count, 2);
        req = '0;
        #1;
        chk("t5_en_abort", cnt_enable, 0);
        tick;                              // cycle 5
        chk("t5_done", done, 2'b01);
        chk("t5_result", result, 2);
        chk("t5_err", err, 0);
        req = 2'b11;
        tick;                              // IDLE sees both
        tick;
        chk("t5_rr_gnt", gnt, 2'b10);
        req = '0;

        // Test 6: async reset mid-run, then pointer back to 0
        do_reset;
        req_len = {4'd3, 4'd10};
        req = 2'b01;
        for (int cy = 1; cy <= 6; cy++) tick;
        chk("t6_count_pre", count, 4);
        chk("t6_en_pre", cnt_enable, 1);
        reset = 1'b1;
        #1;
        chk("t6_gnt_async", gnt, 0);
        chk("t6_en_async", cnt_enable, 0);
        chk("t6_busy_async", busy, 0);
        req = '0;
        tick;
        reset = 1'b0;
        req = 2'b11;
        tick;
        chk("t6_gnt_first", gnt, 2'b01);
        req = '0;
        tick;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
